// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the framed byte-stream boot loader.
// Frame layout: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, CSUM.
package boot_loader_pkg;

  localparam int          BL_HDR_BYTES = 4;
  localparam logic [15:0] BL_MEM_LIMIT = 16'h8000;

  typedef enum logic [3:0] {
    S_ADDR_HI = 4'd0,
    S_ADDR_LO = 4'd1,
    S_LEN_HI  = 4'd2,
    S_LEN_LO  = 4'd3,
    S_DATA    = 4'd4,
    S_CSUM    = 4'd5,
    S_DONE    = 4'd6,
    S_ERR     = 4'd7
  } bl_state_e;

  // Terminal states stop the stream until reload or reset.
  function automatic logic bl_accepts(input bl_state_e s);
    return !((s == S_DONE) || (s == S_ERR));
  endfunction

endpackage

// File: rtl/bl_frame_counter.sv
// Payload byte counter: loads LEN, decrements per accepted byte, flags zero and one.
// Flags are combinational from the registered count; load has priority over decrement.
module bl_frame_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             one
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != CNT_ZERO)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == CNT_ZERO);
  assign one  = (count_q == CNT_ONE);

endmodule

// File: rtl/boot_loader.sv
// Parses a framed image from a valid/ready byte stream into RAM and holds the CPU until loaded.
// Writes land one cycle after each accepted payload byte; in_ready drops only in DONE/ERR.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT  = BL_MEM_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

  bl_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] len_hi_q, len_hi_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] len_val;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  range_bad;
  logic [DATA_WIDTH-1:0] csum_total;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  cnt_one;

  assign xfer       = in_valid && in_ready_q;
  assign len_val    = {len_hi_q, in_data};
  // 17-bit sum so a frame ending exactly at MEM_LIMIT is legal and nothing wraps.
  assign end_addr   = {1'b0, addr_q} + {1'b0, len_val};
  assign range_bad  = addr_q[ADDR_WIDTH-1] || (end_addr > {1'b0, MEM_LIMIT});
  assign csum_total = sum_q + in_data;

  bl_frame_counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_len_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (len_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_hi_d    = len_hi_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      S_ADDR_HI: begin
        sum_d = DATA_ZERO;
        if (xfer) begin
          addr_d[ADDR_WIDTH-1 -: DATA_WIDTH] = in_data;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (xfer) begin
          addr_d[DATA_WIDTH-1:0] = in_data;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          cnt_load = 1'b1;
          ptr_d    = addr_q;
          if (range_bad) begin
            state_d = S_ERR;
          end else if (len_val == ADDR_ZERO) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          state_d = S_CSUM;
        end else if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = in_data;
          ptr_d       = ptr_q + ADDR_ONE;
          sum_d       = csum_total;
          cnt_dec     = 1'b1;
          if (cnt_one) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (csum_total == DATA_ZERO) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_ADDR_HI;
        end
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    in_ready_d = bl_accepts(state_d);
    // Release the CPU only once DONE has been held for a full cycle, after the final write.
    cpu_hold_d = !((state_q == S_DONE) && (state_d == S_DONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ADDR_HI;
      addr_q      <= ADDR_ZERO;
      len_hi_q    <= DATA_ZERO;
      ptr_q       <= ADDR_ZERO;
      sum_q       <= DATA_ZERO;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_ZERO;
      mem_wdata_q <= DATA_ZERO;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_hi_q    <= len_hi_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frame table, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        reload = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  payload[$];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] len;
    bit          bad_csum;
    bit          gappy;
    bit          reload_mid;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gappy, output bit ok);
    int t;
    if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] good_csum();
    logic [7:0] s = 8'h00;
    foreach (payload[i]) s = s + payload[i];
    return 8'h00 - s;
  endfunction

  function automatic bit frame_range_bad(input logic [15:0] addr, input logic [15:0] len);
    return (addr >= 16'h8000) || ((int'(addr) + int'(len)) > 32'h8000);
  endfunction

  task automatic run_frame(input logic [15:0] addr, input logic [15:0] len,
                           input logic [7:0] csum, input bit gappy, input bit reload_mid,
                           input bit exp_done, input bit exp_err);
    logic [7:0] hdr[4];
    bit ok;
    bit rbad;
    int t;
    int nexp;
    rbad = frame_range_bad(addr, len);
    hdr[0] = addr[15:8];
    hdr[1] = addr[7:0];
    hdr[2] = len[15:8];
    hdr[3] = len[7:0];
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr[i], gappy, ok);
      if (!ok) begin
        chk("hdr_accepted", 0, 1);
        return;
      end
      if (reload_mid && i == 1) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
    end
    if (!rbad) begin
      for (int i = 0; i < int'(len); i++) begin
        send_byte(payload[i], gappy, ok);
        if (!ok) begin
          chk("data_accepted", 0, 1);
          return;
        end
      end
      send_byte(csum, gappy, ok);
      if (!ok) begin
        chk("csum_accepted", 0, 1);
        return;
      end
    end
    t = 0;
    while (!(done || err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("outcome_seen", int'(done || err), 1);
    chk("done", int'(done), int'(exp_done));
    chk("err", int'(err), int'(exp_err));
    chk("in_ready_idle", int'(in_ready), 0);
    if (done) begin
      chk("hold_at_done", int'(cpu_hold), 1);
      @(negedge clk);
      chk("hold_after_done", int'(cpu_hold), 0);
    end else begin
      chk("hold_on_err", int'(cpu_hold), 1);
    end
    repeat (3) @(negedge clk);
    nexp = rbad ? 0 : int'(len);
    chk("wr_count", wr_addr.size(), nexp);
    for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
      chk("wr_addr", int'(wr_addr[i]), int'(addr) + i);
      chk("wr_data", int'(wr_data[i]), int'(payload[i]));
    end
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_done", int'(done), 0);
    chk("reload_err", int'(err), 0);
    chk("reload_hold", int'(cpu_hold), 1);
    chk("reload_ready", int'(in_ready), 1);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [15:0] a;
    logic [15:0] l;
    bit          ok;
    bit          bcs;
    bit          rb;

    vecs[0] = '{16'h0010, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0010, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h0100, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0010, 16'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    foreach (vecs[v]) begin
      payload.delete();
      for (int i = 0; i < int'(vecs[v].len); i++) payload.push_back(8'hAA + 8'(8'h11 * i));
      cs = vecs[v].bad_csum ? 8'h00 : good_csum();
      run_frame(vecs[v].addr, vecs[v].len, cs, vecs[v].gappy, vecs[v].reload_mid,
                vecs[v].exp_done, vecs[v].exp_err);
    end

    // Reset in the middle of a payload, then the complete frame again.
    payload.delete();
    for (int i = 0; i < 5; i++) payload.push_back(8'($urandom));
    send_byte(8'h02, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h05, 1'b0, ok);
    send_byte(payload[0], 1'b0, ok);
    in_valid = 1'b1;
    in_data  = payload[1];
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_mem_we", int'(mem_we), 0);
    chk("midrst_hold", int'(cpu_hold), 1);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(16'h0200, 16'd5, good_csum(), 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      l = 16'($urandom_range(0, 10));
      case ($urandom_range(0, 7))
        0:       a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        1:       a = 16'h8000 - l + 16'($urandom_range(0, 1));
        default: a = 16'($urandom_range(0, 16'h7F00));
      endcase
      payload.delete();
      for (int i = 0; i < int'(l); i++) payload.push_back(8'($urandom));
      bcs = ($urandom_range(0, 3) == 0);
      cs  = good_csum() + (bcs ? 8'($urandom_range(1, 255)) : 8'h00);
      rb  = frame_range_bad(a, l);
      run_frame(a, l, cs, ($urandom_range(0, 1) == 1), 1'b0, !rb && !bcs, rb || bcs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
